ulpi_reg_engine: RTL and testbench
==================================

ULPI_REG_ENGINE -- requirements
Module: ulpi_reg_engine

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waited for NXT/DIR in any wait state before abort.
REQ-002 CLK  in  1  ULPI 60 MHz clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 REG_ADDR  in  6  register address from controller.
REQ-005 REG_DATA_WRITE  in  8  write data from controller.
REQ-006 REG_DATA_READ  out  8  read data, valid while REG_READ_ACK high.
REQ-007 REG_WRITE_REQ / REG_READ_REQ  in  1 each  level requests, held until matching ACK.
REQ-008 REG_WRITE_ACK / REG_READ_ACK  out  1 each  completion, four-phase.
REQ-009 REG_TIMEOUT  out  1  high with ACK when transaction ended by timeout.
REQ-010 ULPI_DATA_IN  in  8; ULPI_DATA_OUT  out  8; ULPI_DATA_OE  out  1 (link drives bus).
REQ-011 ULPI_DIR  in  1; ULPI_NXT  in  1; ULPI_STP  out  1.

Function
REQ-012 States: IDLE, W_CMD, W_DATA, W_STP, R_CMD, R_TURN, R_DATA, R_END, ACK.
REQ-013 IDLE: start only when ULPI_DIR low for current and previous cycle; write wins if both REQs high.
REQ-014 Start latches REG_ADDR/REG_DATA_WRITE; later input changes ignored until ACK.
REQ-015 W_CMD drives 8'b10,addr; on NXT -> W_DATA.
REQ-016 W_DATA drives data; on NXT -> W_STP.
REQ-017 W_STP drives 8'h00 with ULPI_STP=1 for exactly one cycle -> ACK.
REQ-018 R_CMD drives 8'b11,addr; on NXT -> R_TURN (OE low from next cycle).
REQ-019 R_TURN: DIR high -> R_DATA; DIR low for TIMEOUT cycles -> timeout.
REQ-020 R_DATA: capture ULPI_DATA_IN into REG_DATA_READ -> R_END.
REQ-021 R_END: wait DIR low -> ACK.
REQ-022 ULPI_DATA_OUT = 8'h00 and ULPI_STP = 0 in IDLE, ACK and all read-turnaround states.
REQ-023 ULPI_DATA_OE = 1 only in W_CMD, W_DATA, W_STP, R_CMD, and only if DIR low this and previous cycle.
REQ-024 DIR rising in W_CMD, W_DATA or R_CMD (before NXT): abort, OE low same cycle, -> IDLE, retry same latched transaction once DIR low two cycles; no ACK.
REQ-025 Wait counter 8 bits, cleared on each state entry and on abort; reaching TIMEOUT -> ACK with REG_TIMEOUT=1, REG_DATA_READ unchanged.
REQ-026 ACK: assert matching ACK (and REG_TIMEOUT if applicable) until its REQ low; then ACK low next cycle -> IDLE.
REQ-027 New transaction never starts in the cycle ACK deasserts.
REQ-028 Latency, write, NXT immediate: REQ seen cycle 0 -> W_CMD cycle 1, W_DATA 2, STP 3, ACK high cycle 4.

Reset
REQ-029 RST: state IDLE, both ACKs 0, REG_TIMEOUT 0, REG_DATA_READ 8'h00, ULPI_DATA_OUT 8'h00, ULPI_DATA_OE 0, ULPI_STP 0, counter 0, DIR history 1.
REQ-030 RST mid-transaction takes effect next edge; bus released immediately, no STP emitted.

Structure
REQ-031 Shared ULPI include holds TX CMD prefixes (REGW 2'b10, REGR 2'b11) and register addresses (FUNC_CTRL 6'h04).
REQ-032 State encoding local to module; no sub-module required.

Verification
REQ-033 Write addr 6'h04 data 8'h49, NXT on cycles 1,2 -> bus 8'h84, 8'h49, 8'h00+STP, WRITE_ACK cycle 4, held until REQ drop.
REQ-034 Read addr 6'h00, PHY NXT, DIR up, data 8'h24 -> REG_DATA_READ 8'h24 with READ_ACK, OE never overlapping DIR.
REQ-035 DIR rises during W_DATA -> OE low same cycle, no ACK, full write retried after DIR low 2 cycles.
REQ-036 NXT never asserted, TIMEOUT=16 -> ACK with REG_TIMEOUT at 17 cycles after W_CMD entry.
REQ-037 Both REQs high in IDLE -> write first, read after write handshake completes.
REQ-038 RST asserted in R_CMD -> next cycle all outputs at reset values; fresh request completes normally.

Source files
------------

// File: rtl/ulpi_reg_engine_pkg.sv
// ULPI link-side constants shared by register-access logic.
// Holds TX CMD prefixes, well-known PHY register addresses and a TX CMD builder.
// No ports; imported by ulpi_reg_engine.
package ulpi_reg_engine_pkg;

    // TX CMD byte prefixes (bits [7:6]) for immediate register access
    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    // PHY register map (immediate addresses)
    localparam logic [5:0] ULPI_REG_VENDOR_ID_LO = 6'h00;
    localparam logic [5:0] ULPI_REG_FUNC_CTRL    = 6'h04;

    // Build a register-access TX CMD byte from prefix and address
    function automatic logic [7:0] txcmd(input logic [1:0] prefix, input logic [5:0] addr);
        return {prefix, addr};
    endfunction

endpackage

// File: rtl/ulpi_reg_engine.sv
// ULPI register read/write engine: turns level REQ/ACK requests into ULPI TX CMD sequences.
// Latency: write with immediate NXT -> ACK 4 cycles after REQ is seen; reads add PHY turnaround.
// Backpressure: PHY stalls via NXT/DIR; controller holds REQ until ACK, ACK held until REQ drops.
// Ports: CLK/RST; REG_* controller side (ADDR, DATA_WRITE, DATA_READ, WRITE/READ REQ+ACK, TIMEOUT);
//        ULPI_* PHY side (DATA_IN/OUT/OE, DIR, NXT, STP).
module ulpi_reg_engine
    import ulpi_reg_engine_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] REG_ADDR,
    input  logic [7:0] REG_DATA_WRITE,
    output logic [7:0] REG_DATA_READ,
    input  logic       REG_WRITE_REQ,
    input  logic       REG_READ_REQ,
    output logic       REG_WRITE_ACK,
    output logic       REG_READ_ACK,
    output logic       REG_TIMEOUT,
    input  logic [7:0] ULPI_DATA_IN,
    output logic [7:0] ULPI_DATA_OUT,
    output logic       ULPI_DATA_OE,
    input  logic       ULPI_DIR,
    input  logic       ULPI_NXT,
    output logic       ULPI_STP
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_CMD,
        S_W_DATA,
        S_W_STP,
        S_R_CMD,
        S_R_TURN,
        S_R_DATA,
        S_R_END,
        S_ACK
    } state_t;

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_prev_q, dir_prev_d;
    logic       is_wr_q, is_wr_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       pending_q, pending_d;      // aborted transaction awaiting retry
    logic       idle_block_q, idle_block_d; // suppress start in the cycle ACK drops
    logic [7:0] rd_shadow_q, rd_shadow_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       timeout_q, timeout_d;
    logic       wr_ack_q, wr_ack_d;
    logic       rd_ack_q, rd_ack_d;
    logic [7:0] data_out_q, data_out_d;
    logic       oe_q, oe_d;
    logic       stp_q, stp_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_prev_d   = ULPI_DIR;
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pending_d    = pending_q;
        idle_block_d = 1'b0;
        rd_shadow_d  = rd_shadow_q;
        rd_data_d    = rd_data_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                // Bus is ours only after DIR has been low for two consecutive cycles
                if (!idle_block_q && !ULPI_DIR && !dir_prev_q) begin
                    if (pending_q) begin
                        pending_d = 1'b0;
                        state_d   = is_wr_q ? S_W_CMD : S_R_CMD;
                    end else if (REG_WRITE_REQ) begin
                        is_wr_d = 1'b1;
                        addr_d  = REG_ADDR;
                        wdata_d = REG_DATA_WRITE;
                        state_d = S_W_CMD;
                    end else if (REG_READ_REQ) begin
                        is_wr_d = 1'b0;
                        addr_d  = REG_ADDR;
                        state_d = S_R_CMD;
                    end
                end
            end
            S_W_CMD, S_W_DATA, S_R_CMD: begin
                if (ULPI_DIR) begin
                    // PHY took the bus before accepting: drop back and replay later
                    state_d   = S_IDLE;
                    pending_d = 1'b1;
                end else if (ULPI_NXT) begin
                    unique case (state_q)
                        S_W_CMD:  state_d = S_W_DATA;
                        S_W_DATA: state_d = S_W_STP;
                        default:  state_d = S_R_TURN;
                    endcase
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = S_ACK;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_W_STP: begin
                state_d = S_ACK;
            end
            S_R_TURN: begin
                if (ULPI_DIR) begin
                    state_d = S_R_DATA;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = S_ACK;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_R_DATA: begin
                rd_shadow_d = ULPI_DATA_IN;
                state_d     = S_R_END;
            end
            S_R_END: begin
                // Read data is only published on a clean finish, so a timeout leaves it intact
                if (!ULPI_DIR) begin
                    state_d   = S_ACK;
                    rd_data_d = rd_shadow_q;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = S_ACK;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK: begin
                if (is_wr_q ? !REG_WRITE_REQ : !REG_READ_REQ) begin
                    state_d      = S_IDLE;
                    idle_block_d = 1'b1;
                    timeout_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end

        // Outputs registered from the next state so they line up with it
        data_out_d = 8'h00;
        unique case (state_d)
            S_W_CMD:  data_out_d = txcmd(TXCMD_REGW, addr_d);
            S_W_DATA: data_out_d = wdata_d;
            S_R_CMD:  data_out_d = txcmd(TXCMD_REGR, addr_d);
            default:  data_out_d = 8'h00;
        endcase
        oe_d     = (state_d == S_W_CMD) || (state_d == S_W_DATA) ||
                   (state_d == S_W_STP) || (state_d == S_R_CMD);
        stp_d    = (state_d == S_W_STP);
        wr_ack_d = (state_d == S_ACK) && is_wr_d;
        rd_ack_d = (state_d == S_ACK) && !is_wr_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            dir_prev_q   <= 1'b1;
            is_wr_q      <= 1'b0;
            addr_q       <= 6'd0;
            wdata_q      <= 8'h00;
            pending_q    <= 1'b0;
            idle_block_q <= 1'b0;
            rd_shadow_q  <= 8'h00;
            rd_data_q    <= 8'h00;
            timeout_q    <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            data_out_q   <= 8'h00;
            oe_q         <= 1'b0;
            stp_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_prev_q   <= dir_prev_d;
            is_wr_q      <= is_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pending_q    <= pending_d;
            idle_block_q <= idle_block_d;
            rd_shadow_q  <= rd_shadow_d;
            rd_data_q    <= rd_data_d;
            timeout_q    <= timeout_d;
            wr_ack_q     <= wr_ack_d;
            rd_ack_q     <= rd_ack_d;
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
            stp_q        <= stp_d;
        end
    end

    // OE drops combinationally the moment DIR rises or reset is applied so the
    // link never fights the PHY, and a reset never emits a stray STP.
    assign ULPI_DATA_OE  = oe_q && !ULPI_DIR && !dir_prev_q && !RST;
    assign ULPI_STP      = stp_q && !RST;
    assign ULPI_DATA_OUT = data_out_q;
    assign REG_DATA_READ = rd_data_q;
    assign REG_WRITE_ACK = wr_ack_q;
    assign REG_READ_ACK  = rd_ack_q;
    assign REG_TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_ulpi_reg_engine.sv
// Directed bench for ulpi_reg_engine with hand-computed expected bus and handshake values.
// Inputs change 2 ns after each rising edge; outputs are sampled 1 ns later.
module tb_ulpi_reg_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] reg_addr;
    logic [7:0] reg_data_write;
    logic [7:0] reg_data_read;
    logic       reg_write_req, reg_read_req;
    logic       reg_write_ack, reg_read_ack;
    logic       reg_timeout;
    logic [7:0] ulpi_data_in, ulpi_data_out;
    logic       ulpi_data_oe, ulpi_dir, ulpi_nxt, ulpi_stp;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] overlap_cnt = 8'd0;

    always #5 clk = ~clk;

    ulpi_reg_engine #(.TIMEOUT(16)) u_dut (
        .CLK            (clk),
        .RST            (rst),
        .REG_ADDR       (reg_addr),
        .REG_DATA_WRITE (reg_data_write),
        .REG_DATA_READ  (reg_data_read),
        .REG_WRITE_REQ  (reg_write_req),
        .REG_READ_REQ   (reg_read_req),
        .REG_WRITE_ACK  (reg_write_ack),
        .REG_READ_ACK   (reg_read_ack),
        .REG_TIMEOUT    (reg_timeout),
        .ULPI_DATA_IN   (ulpi_data_in),
        .ULPI_DATA_OUT  (ulpi_data_out),
        .ULPI_DATA_OE   (ulpi_data_oe),
        .ULPI_DIR       (ulpi_dir),
        .ULPI_NXT       (ulpi_nxt),
        .ULPI_STP       (ulpi_stp)
    );

    // Link and PHY must never drive the bus together
    always @(negedge clk) begin
        if (ulpi_data_oe && ulpi_dir) overlap_cnt <= overlap_cnt + 8'd1;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        reg_addr = 6'd0; reg_data_write = 8'h00;
        reg_write_req = 1'b0; reg_read_req = 1'b0;
        ulpi_data_in = 8'h00; ulpi_dir = 1'b0; ulpi_nxt = 1'b0;

        // ---------------- reset state
        idle(2);
        sample();
        check("rst_out",   ulpi_data_out, 8'h00);
        check("rst_oe",    8'(ulpi_data_oe), 8'h00);
        check("rst_stp",   8'(ulpi_stp), 8'h00);
        check("rst_wack",  8'(reg_write_ack), 8'h00);
        check("rst_rack",  8'(reg_read_ack), 8'h00);
        check("rst_to",    8'(reg_timeout), 8'h00);
        check("rst_rdata", reg_data_read, 8'h00);
        rst = 1'b0;
        idle(2);

        // ---------------- write 0x49 to FUNC_CTRL, NXT immediate
        reg_write_req = 1'b1; reg_addr = 6'h04; reg_data_write = 8'h49;   // cycle 0
        tick(); ulpi_nxt = 1'b1; sample();                                // cycle 1
        check("wr_cmd",    ulpi_data_out, 8'h84);
        check("wr_cmd_oe", 8'(ulpi_data_oe), 8'h01);
        check("wr_cmd_stp",8'(ulpi_stp), 8'h00);
        reg_addr = 6'h3F; reg_data_write = 8'hFF;                          // must be ignored
        tick(); sample();                                                  // cycle 2
        check("wr_data",   ulpi_data_out, 8'h49);
        check("wr_data_oe",8'(ulpi_data_oe), 8'h01);
        tick(); ulpi_nxt = 1'b0; sample();                                 // cycle 3
        check("wr_stp_dat",ulpi_data_out, 8'h00);
        check("wr_stp",    8'(ulpi_stp), 8'h01);
        check("wr_stp_ack",8'(reg_write_ack), 8'h00);
        tick(); sample();                                                  // cycle 4
        check("wr_ack",    8'(reg_write_ack), 8'h01);
        check("wr_ack_to", 8'(reg_timeout), 8'h00);
        check("wr_ack_stp",8'(ulpi_stp), 8'h00);
        check("wr_ack_oe", 8'(ulpi_data_oe), 8'h00);
        tick(); sample();                                                  // cycle 5
        check("wr_ack_hold", 8'(reg_write_ack), 8'h01);
        reg_write_req = 1'b0;
        tick(); sample();                                                  // cycle 6
        check("wr_ack_drop", 8'(reg_write_ack), 8'h00);
        idle(2);

        // ---------------- read addr 0x00, PHY returns 0x24
        reg_read_req = 1'b1; reg_addr = 6'h00;                             // cycle 0
        tick(); ulpi_nxt = 1'b1; sample();                                 // cycle 1
        check("rd_cmd",    ulpi_data_out, 8'hC0);
        check("rd_cmd_oe", 8'(ulpi_data_oe), 8'h01);
        tick(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1; sample();                // cycle 2 (turn)
        check("rd_turn_oe",8'(ulpi_data_oe), 8'h00);
        check("rd_turn_out", ulpi_data_out, 8'h00);
        tick(); ulpi_data_in = 8'h24; sample();                            // cycle 3 (data)
        check("rd_data_oe",8'(ulpi_data_oe), 8'h00);
        tick(); ulpi_dir = 1'b0; ulpi_data_in = 8'h00; sample();           // cycle 4 (end)
        check("rd_end_ack",8'(reg_read_ack), 8'h00);
        tick(); sample();                                                  // cycle 5
        check("rd_ack",    8'(reg_read_ack), 8'h01);
        check("rd_value",  reg_data_read, 8'h24);
        check("rd_ack_to", 8'(reg_timeout), 8'h00);
        check("rd_no_wack",8'(reg_write_ack), 8'h00);
        reg_read_req = 1'b0;
        tick(); sample();                                                  // cycle 6
        check("rd_ack_drop", 8'(reg_read_ack), 8'h00);
        idle(2);

        // ---------------- DIR rises during W_DATA: abort and replay
        reg_write_req = 1'b1; reg_addr = 6'h0A; reg_data_write = 8'h5A;    // cycle 0
        tick(); ulpi_nxt = 1'b1; sample();                                 // cycle 1
        check("ab_cmd",    ulpi_data_out, 8'h8A);
        tick(); sample();                                                  // cycle 2
        check("ab_data",   ulpi_data_out, 8'h5A);
        check("ab_data_oe",8'(ulpi_data_oe), 8'h01);
        ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
        reg_addr = 6'h11; reg_data_write = 8'hEE;                          // must be ignored
        sample();
        check("ab_oe_same_cycle", 8'(ulpi_data_oe), 8'h00);
        tick(); sample();                                                  // cycle 3
        check("ab_idle_oe",  8'(ulpi_data_oe), 8'h00);
        check("ab_idle_out", ulpi_data_out, 8'h00);
        check("ab_no_ack",   8'(reg_write_ack), 8'h00);
        tick(); ulpi_dir = 1'b0; sample();                                 // cycle 4
        check("ab_wait1_oe", 8'(ulpi_data_oe), 8'h00);
        tick(); sample();                                                  // cycle 5
        check("ab_wait2_oe", 8'(ulpi_data_oe), 8'h00);
        check("ab_wait2_ack",8'(reg_write_ack), 8'h00);
        tick(); ulpi_nxt = 1'b1; sample();                                 // cycle 6
        check("ab_retry_cmd",ulpi_data_out, 8'h8A);
        check("ab_retry_oe", 8'(ulpi_data_oe), 8'h01);
        tick(); sample();                                                  // cycle 7
        check("ab_retry_data", ulpi_data_out, 8'h5A);
        tick(); ulpi_nxt = 1'b0; sample();                                 // cycle 8
        check("ab_retry_stp", 8'(ulpi_stp), 8'h01);
        tick(); sample();                                                  // cycle 9
        check("ab_retry_ack", 8'(reg_write_ack), 8'h01);
        reg_write_req = 1'b0;
        tick(); sample();
        check("ab_ack_drop", 8'(reg_write_ack), 8'h00);
        idle(2);

        // ---------------- NXT never comes: timeout with TIMEOUT=16
        reg_write_req = 1'b1; reg_addr = 6'h04; reg_data_write = 8'h11;    // cycle 0
        tick(); sample();                                                  // cycle 1 = W_CMD entry
        check("to_cmd", ulpi_data_out, 8'h84);
        idle(16); sample();                                                // cycle 17
        check("to_not_yet",   8'(reg_write_ack), 8'h00);
        check("to_still_oe",  8'(ulpi_data_oe), 8'h01);
        tick(); sample();                                                  // cycle 18
        check("to_ack",   8'(reg_write_ack), 8'h01);
        check("to_flag",  8'(reg_timeout), 8'h01);
        check("to_rdata_kept", reg_data_read, 8'h24);
        reg_write_req = 1'b0;
        tick(); sample();
        check("to_ack_drop",  8'(reg_write_ack), 8'h00);
        check("to_flag_drop", 8'(reg_timeout), 8'h00);
        idle(2);

        // ---------------- both requests: write first, then read
        reg_write_req = 1'b1; reg_read_req = 1'b1;
        reg_addr = 6'h05; reg_data_write = 8'h33;                          // cycle 0
        tick(); ulpi_nxt = 1'b1; sample();                                 // cycle 1
        check("both_first_is_wr", ulpi_data_out, 8'h85);
        tick(); sample();                                                  // cycle 2
        check("both_wr_data", ulpi_data_out, 8'h33);
        tick(); ulpi_nxt = 1'b0; sample();                                 // cycle 3
        tick(); sample();                                                  // cycle 4
        check("both_wack", 8'(reg_write_ack), 8'h01);
        check("both_no_rack", 8'(reg_read_ack), 8'h00);
        reg_write_req = 1'b0;
        tick(); sample();                                                  // cycle 5: ACK low
        check("both_wack_drop", 8'(reg_write_ack), 8'h00);
        tick(); sample();                                                  // cycle 6: no start yet
        check("both_gap_oe", 8'(ulpi_data_oe), 8'h00);
        tick(); ulpi_nxt = 1'b1; sample();                                 // cycle 7
        check("both_rd_cmd", ulpi_data_out, 8'hC5);
        check("both_rd_oe",  8'(ulpi_data_oe), 8'h01);
        tick(); ulpi_nxt = 1'b0; ulpi_dir = 1'b1; sample();                // cycle 8
        tick(); ulpi_data_in = 8'h7E; sample();                            // cycle 9
        tick(); ulpi_dir = 1'b0; ulpi_data_in = 8'h00; sample();           // cycle 10
        tick(); sample();                                                  // cycle 11
        check("both_rack",  8'(reg_read_ack), 8'h01);
        check("both_rdata", reg_data_read, 8'h7E);
        reg_read_req = 1'b0;
        tick(); sample();
        check("both_rack_drop", 8'(reg_read_ack), 8'h00);
        idle(2);

        // ---------------- reset during R_CMD, then a fresh write
        reg_read_req = 1'b1; reg_addr = 6'h04;                             // cycle 0
        tick(); sample();                                                  // cycle 1
        check("rr_cmd", ulpi_data_out, 8'hC4);
        rst = 1'b1; sample();
        check("rr_oe_released", 8'(ulpi_data_oe), 8'h00);
        check("rr_no_stp",      8'(ulpi_stp), 8'h00);
        tick(); sample();                                                  // cycle 2
        check("rr_out",   ulpi_data_out, 8'h00);
        check("rr_oe",    8'(ulpi_data_oe), 8'h00);
        check("rr_rack",  8'(reg_read_ack), 8'h00);
        check("rr_to",    8'(reg_timeout), 8'h00);
        check("rr_rdata", reg_data_read, 8'h00);
        rst = 1'b0; reg_read_req = 1'b0;
        idle(2);
        reg_write_req = 1'b1; reg_addr = 6'h04; reg_data_write = 8'h49;
        tick(); ulpi_nxt = 1'b1; sample();
        check("rr_fresh_cmd",  ulpi_data_out, 8'h84);
        tick(); sample();
        check("rr_fresh_data", ulpi_data_out, 8'h49);
        tick(); ulpi_nxt = 1'b0; sample();
        check("rr_fresh_stp",  8'(ulpi_stp), 8'h01);
        tick(); sample();
        check("rr_fresh_ack",  8'(reg_write_ack), 8'h01);
        reg_write_req = 1'b0;
        idle(2);

        check("oe_dir_overlap", overlap_cnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
